// File: rtl/seq_mux_if.sv
// Channel-data and select request bundle plus registered-output handshake for seq_mux.
interface seq_mux_if #(
  parameter int N = 16,
  parameter int W = 1
);
  localparam int SELW = $clog2(N);

  logic [N*W-1:0]  in;
  logic [SELW-1:0] sel;
  logic            mode;
  logic            en;
  logic [W-1:0]    out;
  logic [SELW-1:0] out_ch;
  logic            out_last;
  logic            out_valid;
  logic            out_ready;

  modport master (
    output in, sel, mode, en, out_ready,
    input  out, out_ch, out_last, out_valid
  );

  modport slave (
    input  in, sel, mode, en, out_ready,
    output out, out_ch, out_last, out_valid
  );
endinterface

// File: rtl/seq_mux.sv
// Registered N:1 W-bit mux with valid/ready output; channel comes from sel (direct)
// or from an internal round-robin pointer (scan) that persists across direct loads.
module seq_mux #(
  parameter int N = 16,
  parameter int W = 1
) (
  input logic     clk,
  input logic     rst,
  seq_mux_if.slave bus
);
  localparam int SELW = $clog2(N);

  logic [SELW-1:0] scan_ptr;
  logic [SELW-1:0] ch;
  logic [W-1:0]    ch_data;
  logic            at_end;
  logic            load;

  logic [W-1:0]    out_q;
  logic [SELW-1:0] ch_q;
  logic            last_q;
  logic            valid_q;

  assign ch     = bus.mode ? scan_ptr : bus.sel;
  assign at_end = (scan_ptr == SELW'(N - 1));
  assign load   = bus.en && (!valid_q || bus.out_ready);

  // Compare-based select so an out-of-range direct sel yields zero data.
  always_comb begin
    ch_data = '0;
    for (int k = 0; k < N; k++)
      if (ch == SELW'(k)) ch_data = bus.in[k*W +: W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q    <= '0;
      ch_q     <= '0;
      last_q   <= 1'b0;
      valid_q  <= 1'b0;
      scan_ptr <= '0;
    end else if (load) begin
      out_q   <= ch_data;
      ch_q    <= ch;
      last_q  <= bus.mode && at_end;
      valid_q <= 1'b1;
      if (bus.mode) scan_ptr <= at_end ? '0 : scan_ptr + SELW'(1);
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_ch    = ch_q;
  assign bus.out_last  = last_q;
  assign bus.out_valid = valid_q;
endmodule

// File: doc/seq_mux.md
# seq_mux

Parametrised, registered N-channel, W-bit-per-channel multiplexer with a valid/ready output handshake and two select modes: direct (external `sel`) and scan (internal round-robin pointer). It replaces the purely combinational fixed 16:1 single-bit multiplexer wherever a selected stream must be time-division serialised, or must be held against a stalling downstream consumer.

## Interface
- `N`, 16: channel count, N >= 2; need not be a power of two.
- `W`, 1: data width per channel, W >= 1.
- `SELW`, derived as clog2(N): select and channel-index width. This is a local parameter and is not overridable.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `in`  in  N*W: packed channel data; channel k occupies `in[k*W +: W]`.
- `sel`  in  SELW: channel select, used in direct mode only.
- `mode`  in  1: 0 = direct, 1 = scan.
- `en`  in  1: request to load one sample into the output register.
- `out`  out  W: registered selected data.
- `out_ch`  out  SELW: channel index that `out` came from.
- `out_last`  out  1: high when the held sample was scan-mode channel N-1.
- `out_valid`  out  1: output register holds a sample not yet accepted.
- `out_ready`  in  1: downstream accepts the sample when `out_valid` && `out_ready`.

## Operation
- State: output register (`out`, `out_ch`, `out_last`, `out_valid`) plus `scan_ptr`[SELW].
- Effective channel: `ch` = `mode` ? `scan_ptr` : `sel`.
- Load condition: `load` = `en` && (!`out_valid` || `out_ready`). Throughput is one sample per cycle while `out_ready` is held high.
- On `load`:
  - `out` <= `in[ch*W +: W]`
  - `out_ch` <= `ch`
  - `out_last` <= `mode` && (`scan_ptr` == N-1)
  - `out_valid` <= 1
- Scan pointer:
  - On `load` with `mode`=1: `scan_ptr` <= (`scan_ptr` == N-1) ? 0 : `scan_ptr`+1.
  - Otherwise it holds. It also holds across direct-mode cycles, so scanning resumes where it left off.
- Drain: `out_valid` && `out_ready` && !`en` sets `out_valid` <= 0. Data, `out_ch` and `out_last` hold their last values.
- Stall: `out_valid` && !`out_ready` means no register or pointer change, regardless of `en`, `sel` or `mode`.
- Out-of-range direct select (`sel` >= N, possible only when N is not a power of two):
  - The load still occurs, with `out` = 0 and `out_ch` = `sel`.
  - `scan_ptr` is unaffected.
- `mode` may change on any cycle. It takes effect on the next `load` and needs no flush.

## Timing
- Reset (`rst`=1 at an edge) forces `out`=0, `out_ch`=0, `out_last`=0, `out_valid`=0 and `scan_ptr`=0.
- `rst` overrides `en` and `out_ready` in the same cycle. Reset mid-stall discards the held sample.
- Latency is one cycle: inputs sampled at edge t appear on `out` after edge t.
- `in`, `sel` and `mode` matter only in a cycle where `load`=1. They may change freely otherwise.
- Simultaneous accept and load (`out_valid`=1, `out_ready`=1, `en`=1): the old sample is consumed, the new sample is registered in the same edge, and `out_valid` stays 1.
- `out_valid` never falls without a handshake, and `out`/`out_ch` never change while `out_valid` && !`out_ready`.

## Test plan
- Reset, then direct mode with N=16, W=1, `in`=16'hA5C3, `out_ready`=1, `sel` stepping 0..15 with `en`=1 -> one edge later `out` equals `in[sel]` and `out_ch`=`sel` every cycle, e.g. `sel`=0 gives 1 and `sel`=2 gives 0.
- Scan mode, N=5, W=8, `in`={8'h44,8'h33,8'h22,8'h11,8'h00}, `en`=1, `out_ready`=1 for 7 cycles -> `out` sequence 00,11,22,33,44,00,11; `out_last`=1 only on the 44 sample; pointer wraps 4->0.
- Backpressure: scan mode with `out_ready`=0 for 3 cycles after the first load -> `out`, `out_ch` and `scan_ptr` are frozen. When `out_ready` returns to 1 with `en`=1, the next channel loads on that edge with no sample skipped or duplicated.
- Drain and mode switch:
  - Load channel 2 in scan mode, switch to direct with `sel`=7, and load -> `out_ch`=7.
  - Switch back to scan and load -> `out_ch`=3.
  - With `en`=0 and `out_ready`=1 -> `out_valid` drops after one edge.
- Reset mid-operation: assert `rst` during a stall with `out_valid`=1 and `scan_ptr`=3 -> after the edge all outputs are 0, `out_valid`=0, and the next scan load yields channel 0.
- Out-of-range select: N=5, direct mode, `sel`=6, `en`=1 -> `out`=0, `out_ch`=6, `out_valid`=1, `scan_ptr` unchanged.
